// File: rtl/datapath_ctrl_pkg.sv
// Shared types and constants for the datapath sequencing controller.
// DATAPATH_CTRL_TRAP_EN adds the HALT state used to trap illegal instructions.
package datapath_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WRITE_IMM = 3'd2,
        ST_GET_A     = 3'd3,
        ST_GET_B     = 3'd4,
        ST_EXEC      = 3'd5,
        ST_WRITE_REG = 3'd6
`ifdef DATAPATH_CTRL_TRAP_EN
        , ST_HALT    = 3'd7
`endif
    } state_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    // MOV reg routes Rm through the ALU as 0 + sh(Rm).
    function automatic logic [1:0] exec_aluop(input logic is_alu, input logic [1:0] op);
        return is_alu ? op : ALU_ADD;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction field extraction, imm8 sign extension and
// legal/illegal classification for datapath_ctrl.
module instr_decode
    import datapath_ctrl_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic [DW-1:0] ir,
    output logic [RW-1:0] rn,
    output logic [RW-1:0] rd,
    output logic [RW-1:0] rm,
    output logic [1:0]    sh,
    output logic [1:0]    op,
    output logic [DW-1:0] sximm8,
    output logic          is_mov_imm,
    output logic          is_mov_reg,
    output logic          is_alu,
    output logic          is_cmp,
    output logic          is_illegal
);

    logic [2:0]           opcode;
    logic signed [7:0]    imm8;
    logic signed [DW-1:0] imm_sx;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign imm8   = ir[7:0];
    assign imm_sx = {{(DW-8){imm8[7]}}, imm8};
    assign sximm8 = imm_sx;

    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_alu     = (opcode == OPC_ALU);
    assign is_cmp     = is_alu && (op == OP_CMP);
    assign is_illegal = !(is_mov_imm || is_mov_reg || is_alu);

endmodule

// File: rtl/datapath_ctrl.sv
// Moore sequencing controller for the regfile/shifter/ALU datapath.
// Define DATAPATH_CTRL_TRAP_EN to trap illegal instructions in HALT (err=1).
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s,
    input  logic [DW-1:0] instr,
    output logic          w,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          vsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic [DW-1:0] sximm8,
    output logic          err
);

    state_t        state, state_nxt;
    logic [DW-1:0] ir;
    logic [RW-1:0] rn, rd, rm;
    logic [1:0]    sh, op;
    logic          is_mov_imm, is_mov_reg, is_alu, is_cmp, is_illegal;

    instr_decode #(.DW(DW), .RW(RW)) u_decode (
        .ir         (ir),
        .rn         (rn),
        .rd         (rd),
        .rm         (rm),
        .sh         (sh),
        .op         (op),
        .sximm8     (sximm8),
        .is_mov_imm (is_mov_imm),
        .is_mov_reg (is_mov_reg),
        .is_alu     (is_alu),
        .is_cmp     (is_cmp),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_WAIT && s)
                ir <= instr;
        end
    end

    always_comb begin
        state_nxt = state;
        w         = 1'b0;
        readnum   = '0;
        writenum  = '0;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        vsel      = 1'b0;
        shift     = SH_NONE;
        ALUop     = ALU_ADD;
        err       = 1'b0;
        case (state)
            ST_WAIT: begin
                w = 1'b1;
                if (s)
                    state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_illegal)
`ifdef DATAPATH_CTRL_TRAP_EN
                    state_nxt = ST_HALT;
`else
                    state_nxt = ST_WAIT;
`endif
                else if (is_mov_imm)
                    state_nxt = ST_WRITE_IMM;
                else if (is_mov_reg)
                    state_nxt = ST_GET_B;
                else
                    state_nxt = ST_GET_A;
            end
            ST_WRITE_IMM: begin
                writenum  = rn;
                vsel      = 1'b1;
                write     = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_GET_A: begin
                readnum   = rn;
                loada     = 1'b1;
                state_nxt = ST_GET_B;
            end
            ST_GET_B: begin
                readnum   = rm;
                loadb     = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                shift = sh;
                ALUop = exec_aluop(is_alu, op);
                asel  = is_mov_reg;
                // CMP only updates status; nothing is written back.
                if (is_cmp) begin
                    loads     = 1'b1;
                    state_nxt = ST_WAIT;
                end else begin
                    loadc     = 1'b1;
                    state_nxt = ST_WRITE_REG;
                end
            end
            ST_WRITE_REG: begin
                writenum  = rd;
                write     = 1'b1;
                state_nxt = ST_WAIT;
            end
`ifdef DATAPATH_CTRL_TRAP_EN
            ST_HALT: begin
                err       = 1'b1;
                state_nxt = ST_HALT;
            end
`endif
            default: state_nxt = ST_WAIT;
        endcase
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Self-checking bench for datapath_ctrl: directed and random instructions
// compared cycle by cycle against a per-instruction behavioural step list.
module tb_datapath_ctrl;

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        vsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic [15:0] sximm8;
        logic        err;
    } out_t;

    logic        clk;
    logic        rst_n;
    logic        s;
    logic [15:0] instr;
    logic        w, write, loada, loadb, loadc, loads, asel, vsel, err;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm8;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_ir;
    out_t exp_q[$];
    bit   exp_halt;

    datapath_ctrl #(.DW(16), .RW(3)) dut (
        .clk(clk), .rst_n(rst_n), .s(s), .instr(instr), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    function automatic out_t sample();
        out_t o;
        o.w = w; o.readnum = readnum; o.writenum = writenum; o.write = write;
        o.loada = loada; o.loadb = loadb; o.loadc = loadc; o.loads = loads;
        o.asel = asel; o.vsel = vsel; o.shift = shift; o.aluop = ALUop;
        o.sximm8 = sximm8; o.err = err;
        return o;
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] b);
        int v;
        v = (b >= 8'd128) ? int'(b) - 256 : int'(b);
        return 16'(v);
    endfunction

    function automatic out_t blank(input logic [15:0] ir);
        out_t o;
        o = '0;
        o.sximm8 = sext8(ir[7:0]);
        return o;
    endfunction

    function automatic out_t idle_out(input logic [15:0] ir);
        out_t o;
        o = blank(ir);
        o.w = 1'b1;
        return o;
    endfunction

    // Outputs expected on each edge after s is taken, ending back in WAIT
    // (or in the trap state when traps are built in).
    function automatic void build_seq(input logic [15:0] ins);
        out_t o;
        logic [2:0] opc;
        logic [1:0] op;
        bit mov_imm, mov_reg, alu;
        opc = ins[15:13];
        op  = ins[12:11];
        mov_imm = (opc == 3'b110) && (op == 2'b10);
        mov_reg = (opc == 3'b110) && (op == 2'b00);
        alu     = (opc == 3'b101);
        exp_q.delete();
        exp_halt = 1'b0;
        exp_q.push_back(blank(ins));
        if (mov_imm) begin
            o = blank(ins); o.writenum = ins[10:8]; o.vsel = 1; o.write = 1;
            exp_q.push_back(o);
        end else if (mov_reg || alu) begin
            if (alu) begin
                o = blank(ins); o.readnum = ins[10:8]; o.loada = 1;
                exp_q.push_back(o);
            end
            o = blank(ins); o.readnum = ins[2:0]; o.loadb = 1;
            exp_q.push_back(o);
            o = blank(ins); o.shift = ins[4:3];
            o.aluop = alu ? op : 2'b00;
            o.asel  = mov_reg;
            if (alu && op == 2'b01) o.loads = 1; else o.loadc = 1;
            exp_q.push_back(o);
            if (!(alu && op == 2'b01)) begin
                o = blank(ins); o.writenum = ins[7:5]; o.write = 1;
                exp_q.push_back(o);
            end
        end else begin
`ifdef DATAPATH_CTRL_TRAP_EN
            o = blank(ins); o.err = 1;
            exp_q.push_back(o);
            exp_halt = 1'b1;
`endif
        end
        if (!exp_halt)
            exp_q.push_back(idle_out(ins));
    endfunction

    task automatic reset_pulse(input string name);
        out_t got;
        @(negedge clk);
        rst_n = 1'b0;
        s = 1'b0;
        #1;
        got = sample();
        checks++;
        if (got !== idle_out(16'h0000)) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, idle_out(16'h0000));
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_ir = 16'h0000;
    endtask

    task automatic run_instr(input logic [15:0] ins, input bit hold, input string name);
        out_t got;
        build_seq(ins);
        @(negedge clk);
        s = 1'b1;
        instr = ins;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); #1;
            got = sample();
            checks++;
            if (got !== exp_q[k]) begin
                errors++;
                $display("FAIL %s ins %h step %0d got %h exp %h", name, ins, k, got, exp_q[k]);
            end
            if (k == 0) begin
                s = hold;
                if (!hold) instr = 16'($urandom);
            end
        end
        last_ir = ins;
        if (exp_halt) begin
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                s = 1'($urandom);
                instr = 16'($urandom);
                @(posedge clk); #1;
                got = sample();
                checks++;
                if (got !== exp_q[exp_q.size()-1]) begin
                    errors++;
                    $display("FAIL %s halt cycle %0d got %h exp %h", name, c, got, exp_q[exp_q.size()-1]);
                end
            end
            reset_pulse("halt_reset");
        end
    endtask

    task automatic test_reset();
        out_t got;
        rst_n = 1'b0; s = 1'b0; instr = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        got = sample();
        checks++;
        if (got !== idle_out(16'h0000)) begin
            errors++;
            $display("FAIL reset_hold got %h exp %h", got, idle_out(16'h0000));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        got = sample();
        checks++;
        if (got !== idle_out(16'h0000)) begin
            errors++;
            $display("FAIL reset_release got %h exp %h", got, idle_out(16'h0000));
        end
        last_ir = 16'h0000;
    endtask

    task automatic test_mid_reset();
        out_t got;
        @(negedge clk);
        s = 1'b1; instr = 16'hA148;
        @(posedge clk); #1;
        s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (loadb !== 1'b1 || readnum !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_getb got loadb %b readnum %0d exp 1 0", loadb, readnum);
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = sample();
        checks++;
        if (got !== idle_out(16'h0000)) begin
            errors++;
            $display("FAIL mid_reset_async got %h exp %h", got, idle_out(16'h0000));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            got = sample();
            checks++;
            if (got !== idle_out(16'h0000)) begin
                errors++;
                $display("FAIL mid_reset_after cycle %0d got %h exp %h", c, got, idle_out(16'h0000));
            end
        end
        last_ir = 16'h0000;
    endtask

    task automatic test_directed();
        run_instr(16'hD007, 1'b0, "mov_imm_pos");
        run_instr(16'hD1FE, 1'b0, "mov_imm_neg");
        run_instr(16'hA148, 1'b0, "add_lsl");
        run_instr(16'hA900, 1'b0, "cmp");
        run_instr(16'hC0AA, 1'b0, "mov_reg");
        run_instr(16'hB2F7, 1'b0, "and");
        run_instr(16'hBB1D, 1'b0, "pass");
        run_instr(16'h0000, 1'b0, "illegal_zero");
    endtask

    task automatic test_back_to_back();
        run_instr(16'hD07F, 1'b1, "b2b_mov_imm");
        run_instr(16'hA148, 1'b1, "b2b_add");
        run_instr(16'hA900, 1'b0, "b2b_cmp");
    endtask

    task automatic test_idle_isolation();
        out_t got;
        @(negedge clk);
        s = 1'b0;
        for (int c = 0; c < 6; c++) begin
            instr = 16'($urandom);
            #1;
            got = sample();
            checks++;
            if (got !== idle_out(last_ir)) begin
                errors++;
                $display("FAIL idle_comb %0d got %h exp %h", c, got, idle_out(last_ir));
            end
            @(posedge clk); #1;
            got = sample();
            checks++;
            if (got !== idle_out(last_ir)) begin
                errors++;
                $display("FAIL idle_hold %0d got %h exp %h", c, got, idle_out(last_ir));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        bit hold;
        for (int i = 0; i < 60; i++) begin
            ins = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ins[15:11] = 5'b11010;
                1: ins[15:11] = 5'b11000;
                2: ins[15:13] = 3'b101;
                default: ;
            endcase
            hold = (i != 59) && ($urandom_range(0, 3) == 0);
            run_instr(ins, hold, "random");
        end
        @(negedge clk);
        s = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mid_reset();
        test_directed();
        test_back_to_back();
        test_idle_isolation();
        test_random();
        test_idle_isolation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Moore-style sequencing controller sitting directly upstream of the register-file / shifter / ALU datapath. It accepts one 16-bit instruction per start pulse and decodes it. It then steps the datapath through register read, shift/ALU execute and write-back by driving every datapath load, select and opcode input. It raises `w` when idle and ready for the next instruction.

## Interface
- `DW`, 16: datapath/instruction width.
- `RW`, 3: register index width.
- `clk` input 1: clock, all state changes on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `s` input 1: start; sampled only in WAIT.
- `instr` input DW: instruction; captured into IR when `s`=1 in WAIT.
- `w` output 1: 1 only in WAIT.
- `readnum` / `writenum` output RW: regfile read/write index.
- `write` output 1: regfile write enable.
- `loada`, `loadb`, `loadc`, `loads` output 1: datapath register enables (A, B, C, status).
- `asel` output 1: 1 forces ALU A input to zero.
- `vsel` output 1: 0 writes C, 1 writes `sximm8`.
- `shift` output 2: shifter control, IR[4:3].
- `ALUop` output 2: 00 add, 01 sub, 10 and, 11 pass A.
- `sximm8` output DW: IR[7:0] sign-extended.
- `err` output 1: illegal-instruction flag (see Configuration).

## Operation
- Instruction fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0], imm8 IR[7:0].
- Legal: opcode 110 op 10 = MOV Rn,#imm8; 110 op 00 = MOV Rd,Rm{sh}; 101 op 00/01/10/11 = ADD/CMP/AND/PASS (Rd = Rn op sh(Rm); CMP writes status only). Everything else is illegal.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG, HALT (only with macro).
- WAIT: `w`=1. If `s`=1, capture IR and go to DECODE; otherwise stay.
- DECODE goes to WRITE_IMM for MOV imm, GET_B for MOV reg, GET_A for ALU ops, and illegal (see Configuration).
- WRITE_IMM: `writenum`=Rn, `vsel`=1, `write`=1, then WAIT.
- GET_A: `readnum`=Rn, `loada`=1, then GET_B.
- GET_B: `readnum`=Rm, `loadb`=1, then EXEC.
- EXEC: `shift`=sh; ALUop from op (MOV reg: `asel`=1, ALUop 00).
  - CMP: `loads`=1, `loadc`=0, then WAIT.
  - Otherwise: `loadc`=1, then WRITE_REG.
- WRITE_REG: `writenum`=Rd, `vsel`=0, `write`=1, then WAIT.
- All outputs not named for a state are 0. `readnum`/`writenum` are 0 when unused.
- `sximm8` tracks IR continuously.
- Reset: state WAIT, IR 0, `w`=1, `err`=0, all other outputs 0. Asserting reset mid-instruction aborts it with no further write.

## Timing
- Outputs are a function of state and IR only; `s` and `instr` never reach the outputs combinationally.
- Cycles from the `s` edge back to WAIT (`w`=1): MOV imm 3, CMP 5, MOV reg 5, ADD/AND/PASS 6.
- `s` held high while returning to WAIT starts the next instruction on the first WAIT edge.
- `s` and `instr` changes outside WAIT are ignored.

## Configuration
- `DATAPATH_CTRL_TRAP_EN` defined: an illegal opcode in DECODE goes to HALT. HALT sets `err`=1, `w`=0 and all enables 0, and is left only by `rst_n`.
- Not defined: an illegal opcode returns from DECODE to WAIT as a NOP; `err` is tied 0 and the HALT state does not exist.

## Structure
- Shared package `datapath_ctrl_pkg`: state enum, opcode/op constants, ALUop constants (ADD/SUB/AND/PASS), shift codes.
- Sub-module `instr_decode`: combinational field extraction, `sximm8` sign extension, legal/illegal classification. The FSM lives in `datapath_ctrl`.

## Test plan
- Reset low during GET_B of an ADD, then release → `w`=1, `write`=0, state WAIT, `sximm8`=0.
- `instr`=16'hD007 (MOV R0,#7) with `s` pulse:
  - DECODE on the next edge.
  - WRITE_IMM on the following edge, with `write`=1, `writenum`=0, `vsel`=1, `sximm8`=16'h0007.
  - `w`=1 three edges after `s`.
- `instr`=16'hD1FE (MOV R1,#-2) → `sximm8`=16'hFFFE in WRITE_IMM, `writenum`=1.
- `instr`=16'hA148 (ADD R2,R1,R0 LSL1):
  - GET_A: `readnum`=1, `loada`=1.
  - GET_B: `readnum`=0, `loadb`=1.
  - EXEC: `shift`=01, `ALUop`=00, `loadc`=1.
  - WRITE_REG: `writenum`=2, `write`=1.
  - `w` returns after 6 edges.
- `instr`=16'hA900 (CMP R1,R0) → EXEC has `ALUop`=01, `loads`=1, `loadc`=0; no `write` pulse; `w` returns after 5 edges.
- `instr`=16'h0000 with `s` pulse:
  - With macro: `err`=1 and `w`=0 persist for 20 cycles until `rst_n` low.
  - Without macro: `w`=1 after 2 edges, `err`=0.
